// File: rtl/wr_flow_frontend.sv
// Write-side front end of an async FIFO: skid-buffered upstream intake, read-pointer
// synchroniser and optional fill level (compile with WR_FLOW_LEVEL_EN to enable level logic).
module wr_flow_frontend #(
    parameter int          ADDR_WIDTH   = 4,
    parameter int          DATA_WIDTH   = 8,
    parameter int unsigned AFULL_THRESH = (2 ** ADDR_WIDTH) - 2
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
    input  logic                  fifo_full,
    output logic [ADDR_WIDTH:0]   rdptr_sync,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  almost_full
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_SKID = 2'd2;

    logic [ADDR_WIDTH:0]   sync1_q;
    logic [ADDR_WIDTH:0]   sync2_q;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  s_ready_q;
    logic                  s_ready_d;

    logic                  main_valid;
    logic                  accept;
    logic                  consume;

    // Plain two-flop synchroniser; nothing may sit between the stages.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= rd_ptr_gray;
            sync2_q <= sync1_q;
        end
    end

    assign rdptr_sync = sync2_q;

    assign main_valid = (state_q == ST_HOLD) || (state_q == ST_SKID);
    assign consume    = main_valid && !fifo_full;
    assign accept     = s_valid && s_ready_q;

    assign wr_en   = consume;
    assign wr_data = main_q;
    assign s_ready = s_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_HOLD;
                    main_d  = s_data;
                end
            end
            ST_HOLD: begin
                if (accept && consume) begin
                    main_d = s_data;
                end else if (accept) begin
                    state_d = ST_SKID;
                    skid_d  = s_data;
                end else if (consume) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SKID: begin
                if (consume) begin
                    state_d = ST_HOLD;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Ready is a pure function of the next state so it can be registered.
        s_ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q   <= ST_IDLE;
            main_q    <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_ready_q <= s_ready_d;
        end
    end

`ifdef WR_FLOW_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH + 1)'(AFULL_THRESH);

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_WIDTH:0] level_d;
    logic [ADDR_WIDTH:0] level_q;
    logic                afull_q;

    // Subtraction wraps modulo 2^(ADDR_WIDTH+1), which covers pointer wrap-around.
    assign level_d = gray2bin(wr_ptr_gray) - gray2bin(sync2_q);

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_d;
            afull_q <= (level_d >= AFULL_LVL);
        end
    end

    assign wr_level    = level_q;
    assign almost_full = afull_q;
`else
    logic unused_level;

    assign unused_level = ^{wr_ptr_gray, AFULL_THRESH[0]};
    assign wr_level     = '0;
    assign almost_full  = 1'b0;
`endif

endmodule

// File: doc/wr_flow_frontend.md
WR_FLOW_FRONTEND -- requirements
Module: wr_flow_frontend

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, FIFO address width (depth 2^ADDR_WIDTH).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, payload width.
REQ-003 The block SHALL have parameter AFULL_THRESH, default 2^ADDR_WIDTH-2, almost-full level threshold.
REQ-004 The block SHALL have port wr_clk  input  1  write-domain clock.
REQ-005 The block SHALL have port wr_rst_n  input  1  write-domain reset, asynchronous, active-low.
REQ-006 The block SHALL have port s_valid  input  1  upstream word valid.
REQ-007 The block SHALL have port s_data  input  DATA_WIDTH  upstream word.
REQ-008 The block SHALL have port s_ready  output  1  upstream may transfer (registered).
REQ-009 The block SHALL have port rd_ptr_gray  input  ADDR_WIDTH+1  Gray read pointer, read-clock domain (asynchronous).
REQ-010 The block SHALL have port wr_ptr_gray  input  ADDR_WIDTH+1  Gray write pointer from write-pointer/full control.
REQ-011 The block SHALL have port fifo_full  input  1  registered full flag from write-pointer/full control.
REQ-012 The block SHALL have port rdptr_sync  output  ADDR_WIDTH+1  read pointer synchronised into wr_clk, fed to write-pointer/full control.
REQ-013 The block SHALL have port wr_en  output  1  write request to write-pointer/full control and memory.
REQ-014 The block SHALL have port wr_data  output  DATA_WIDTH  write data to memory, valid when wr_en=1.
REQ-015 The block SHALL have port wr_level  output  ADDR_WIDTH+1  registered fill level, range 0..2^ADDR_WIDTH.
REQ-016 The block SHALL have port almost_full  output  1  registered, wr_level >= AFULL_THRESH.

Function
REQ-017 rdptr_sync SHALL be a two-flop synchroniser of rd_ptr_gray on wr_clk; latency exactly 2 edges, no logic between flops.
REQ-018 Accept SHALL occur when s_valid=1 and s_ready=1 at a rising wr_clk edge.
REQ-019 Buffering SHALL use a main register and one skid register; state machine IDLE (none held), HOLD (main valid), SKID (main+skid valid).
REQ-020 wr_en SHALL equal main_valid AND NOT fifo_full (combinational); wr_data SHALL equal main register contents; consume = wr_en.
REQ-021 IDLE: accept -> HOLD (load main); else stay IDLE.
REQ-022 HOLD: accept+consume -> HOLD (reload main); accept, no consume -> SKID (load skid); consume only -> IDLE; else HOLD.
REQ-023 SKID: consume -> HOLD (skid moves to main); else SKID; no accept possible.
REQ-024 s_ready SHALL be 1 in IDLE/HOLD, 0 in SKID, driven from a register; no combinational path s_valid/fifo_full -> s_ready.
REQ-025 Words SHALL leave in acceptance order; none dropped or duplicated; accept-to-wr_en latency minimum 1 cycle.
REQ-026 wr_level SHALL be registered gray2bin(wr_ptr_gray) - gray2bin(rdptr_sync), modulo 2^(ADDR_WIDTH+1), covering pointer wrap.
REQ-027 almost_full SHALL be registered from the same-cycle level comparison (both update together, 1 cycle after inputs).
REQ-028 fifo_full asserted while main valid SHALL hold main and wr_data stable until fifo_full drops.

Reset
REQ-029 On wr_rst_n=0 all registers SHALL clear asynchronously: state IDLE, main/skid valid 0, s_ready 0, rdptr_sync 0, wr_level 0, almost_full 0.
REQ-030 wr_en SHALL be 0 during reset; s_ready SHALL rise at first wr_clk edge after release.
REQ-031 Reset mid-operation SHALL discard held words without producing wr_en.

Configuration
REQ-032 Macro WR_FLOW_LEVEL_EN defined: wr_level and almost_full logic per REQ-026/027 compiled in.
REQ-033 WR_FLOW_LEVEL_EN undefined: gray-to-binary and level logic removed; wr_level and almost_full tied 0; all other behaviour unchanged.

Verification (ADDR_WIDTH=4, AFULL_THRESH=14)
REQ-034 Reset release, idle inputs -> wr_en=0 throughout, s_ready=1 after first edge, rdptr_sync=0.
REQ-035 fifo_full=0, s_valid held, s_data 0x01..0x05 -> wr_en each cycle from 1 cycle after first accept, wr_data 0x01..0x05 in order.
REQ-036 fifo_full=1, stream 0xA0,0xA1,0xA2 -> 0xA0,0xA1 accepted, s_ready=0, wr_en=0; fifo_full->0 -> wr_data 0xA0 then 0xA1, then 0xA2 accepted.
REQ-037 rd_ptr_gray 5'b00000 -> 5'b00001 -> rdptr_sync=5'b00001 after exactly 2 wr_clk edges.
REQ-038 wr_ptr_gray=5'b01001 (14), rdptr_sync=0 -> wr_level=14, almost_full=1; wr_ptr_gray=5'b00001 (1), rdptr_sync=5'b11001 (17) -> wr_level=16.
REQ-039 WR_FLOW_LEVEL_EN undefined, same stimulus as REQ-038 -> wr_level=0, almost_full=0.
